// File: rtl/misao_serial_alu.sv
// Digit-serial ALU: one DIGIT_W-bit digit per clock, LSB digit first, over
// 1..DIGITS digits selected per operation. Results/flags update on entry to DONE.
module misao_serial_alu #(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned DIGITS  = 4,
  localparam int unsigned W      = DIGIT_W * DIGITS,
  localparam int unsigned LEN_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             carry_en_i,
  input  logic             carry_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [W-1:0]     result_o,
  output logic             carry_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_INC = 4'd2, OP_DEC = 4'd3, OP_AND = 4'd4,
    OP_OR  = 4'd5, OP_XOR = 4'd6, OP_INV = 4'd7, OP_SHL = 4'd8, OP_SHR = 4'd9
  } op_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d, k_q, k_d, len_in;
  logic               cin_q, cin_d, c_q, c_d, nz_q, nz_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic               carry_q, carry_d, zero_q, zero_d;

  logic [DIGIT_W-1:0] da, db, dig;
  logic [DIGIT_W:0]   ext;
  logic               cnext, last, shr_nx, shr_in, cin_in;

  assign len_in = (len_i > LEN_W'(DIGITS - 1)) ? LEN_W'(DIGITS - 1) : len_i;
  assign cin_in = carry_en_i & carry_i;

  // Per-digit datapath; c_q carries the chain bit between consecutive digits
  always_comb begin
    da     = DIGIT_W'(a_q >> (DIGIT_W * 32'(k_q)));
    db     = DIGIT_W'(b_q >> (DIGIT_W * 32'(k_q)));
    last   = (k_q == len_q);
    // SHR pulls the top bit of digit k from latched digit k+1, or cin at the top
    shr_nx = |(a_q & (W'(1) << (DIGIT_W * (32'(k_q) + 1))));
    shr_in = last ? cin_q : shr_nx;
    ext    = '0;
    dig    = da;
    cnext  = 1'b0;
    case (op_q)
      OP_ADD: begin
        ext   = {1'b0, da} + {1'b0, db} + (DIGIT_W+1)'(c_q);
        dig   = ext[DIGIT_W-1:0];
        cnext = ext[DIGIT_W];
      end
      OP_INC: begin
        ext   = {1'b0, da} + (DIGIT_W+1)'(c_q);
        dig   = ext[DIGIT_W-1:0];
        cnext = ext[DIGIT_W];
      end
      OP_SUB: begin
        ext   = {1'b0, da} - {1'b0, db} - (DIGIT_W+1)'(c_q);
        dig   = ext[DIGIT_W-1:0];
        cnext = ext[DIGIT_W];
      end
      OP_DEC: begin
        ext   = {1'b0, da} - (DIGIT_W+1)'(c_q);
        dig   = ext[DIGIT_W-1:0];
        cnext = ext[DIGIT_W];
      end
      OP_AND: dig = da & db;
      OP_OR:  dig = da | db;
      OP_XOR: dig = da ^ db;
      OP_INV: dig = ~da;
      OP_SHL: begin
        dig   = DIGIT_W'({da, c_q});
        cnext = da[DIGIT_W-1];
      end
      OP_SHR: begin
        dig   = DIGIT_W'({shr_in, da} >> 1);
        cnext = a_q[0];
      end
      default: dig = da;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    cin_d   = cin_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    c_d     = c_q;
    nz_d    = nz_q;
    acc_d   = acc_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          op_d    = op_i;
          len_d   = len_in;
          cin_d   = cin_in;
          a_d     = a_i;
          b_d     = b_i;
          k_d     = '0;
          nz_d    = 1'b0;
          acc_d   = '0;
          case (op_i)
            OP_ADD, OP_SUB, OP_SHL: c_d = cin_in;
            OP_INC, OP_DEC:         c_d = 1'b1;
            default:                c_d = 1'b0;
          endcase
        end
      end
      S_RUN: begin
        acc_d = acc_q | (W'(dig) << (DIGIT_W * 32'(k_q)));
        c_d   = cnext;
        nz_d  = nz_q | (|dig);
        k_d   = k_q + LEN_W'(1);
        if (last) begin
          state_d = S_DONE;
          res_d   = acc_d;
          carry_d = cnext;
          zero_d  = ~nz_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      len_q   <= '0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      nz_q    <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      c_q     <= c_d;
      nz_q    <= nz_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = ~ready_o;
  assign done_o   = (state_q == S_DONE);
  assign result_o = res_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_misao_serial_alu.sv
// Scoreboard bench for misao_serial_alu: driver pushes model results, monitor
// pops and compares on every done_o pulse, and checks output hold between pulses.
module tb_misao_serial_alu;
  localparam int DW = 4;
  localparam int ND = 4;
  localparam int W  = DW * ND;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [3:0]    op_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          carry_en_i = 1'b0;
  logic          carry_i = 1'b0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          ready_o, busy_o, done_o, carry_o, zero_o;
  logic [W-1:0]  result_o;

  misao_serial_alu #(.DIGIT_W(DW), .DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .len_i(len_i),
    .carry_en_i(carry_en_i), .carry_i(carry_i), .a_i(a_i), .b_i(b_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .carry_o(carry_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    int           len;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Whole-word reference: arithmetic on the active width, modulo 2^(4*(len+1))
  function automatic exp_t model(input int op, input int len, input bit cen, input bit ci,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    int     wa  = DW * (len + 1);
    longint m   = (longint'(1) << wa) - 1;
    longint av  = longint'(a) & m;
    longint bv  = longint'(b) & m;
    longint cin = (cen && ci) ? 1 : 0;
    longint r;
    bit     c   = 1'b0;
    case (op)
      0: begin r = av + bv + cin; c = (r > m); end
      1: begin r = av - bv - cin; c = (r < 0); end
      2: begin r = av + 1;        c = (r > m); end
      3: begin r = av - 1;        c = (r < 0); end
      4: r = av & bv;
      5: r = av | bv;
      6: r = av ^ bv;
      7: r = ~av;
      8: begin r = (av << 1) | cin;          c = ((av >> (wa - 1)) & 1) != 0; end
      9: begin r = (av >> 1) | (cin << (wa - 1)); c = a[0]; end
      default: r = av;
    endcase
    e.res = W'(r & m);
    e.c   = c;
    e.z   = (e.res == '0);
    e.len = len;
    e.acc = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op, input int len, input bit cen, input bit ci,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int hold = 0);
    exp_t e;
    int   t = 0;
    while (!ready_o && t < 64) begin
      step();
      t++;
    end
    if (!ready_o) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    op_i       = 4'(op);
    len_i      = LW'(len);
    carry_en_i = cen;
    carry_i    = ci;
    a_i        = a;
    b_i        = b;
    start_i    = 1'b1;
    e          = model(op, len, cen, ci, a, b);
    e.acc      = cyc;
    sb.push_back(e);
    step();
    repeat (hold) step();
    start_i    = 1'b0;
    op_i       = 4'($urandom);
    len_i      = LW'($urandom);
    carry_en_i = 1'($urandom);
    carry_i    = 1'($urandom);
    a_i        = W'($urandom);
    b_i        = W'($urandom);
  endtask

  logic [W-1:0] h_res = '0;
  logic         h_c = 1'b0;
  logic         h_z = 1'b0;
  bit           pend = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pend = 1'b1;
    end else begin
      if (pend) begin
        h_res = '0;
        h_c   = 1'b0;
        h_z   = 1'b0;
        pend  = 1'b0;
      end
      chk("busy_vs_ready", busy_o, !ready_o);
      if (done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", result_o, e.res);
          chk("carry", carry_o, e.c);
          chk("zero", zero_o, e.z);
          chk("latency", cyc - e.acc, e.len + 2);
          h_res = e.res;
          h_c   = e.c;
          h_z   = e.z;
        end
      end else begin
        chk("hold_result", result_o, h_res);
        chk("hold_carry", carry_o, h_c);
        chk("hold_zero", zero_o, h_z);
      end
    end
  end

  initial begin
    exp_t         e;
    logic [W-1:0] acc;
    int           t;
    int           ln;

    repeat (3) step();
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_carry", carry_o, 0);
    chk("rst_zero", zero_o, 0);
    rst = 1'b0;
    step();

    issue(0, 0, 0, 0, 16'h0001, 16'h0003);
    acc = 16'h0001;
    repeat (3) begin
      e = model(0, 0, 0, 0, acc, 16'h0003);
      issue(0, 0, 0, 0, acc, 16'h0003);
      acc = e.res;
    end
    issue(0, 3, 0, 0, 16'hFFFF, 16'h0001);
    issue(0, 1, 0, 0, 16'hFFFF, 16'h0001);
    issue(1, 1, 1, 1, 16'h0010, 16'h0020);
    issue(3, 0, 0, 0, 16'h0000, 16'h0000);
    issue(8, 3, 1, 1, 16'h8001, 16'h0000);
    issue(9, 3, 0, 0, 16'h8001, 16'h0000);
    issue(2, 3, 1, 1, 16'hFFFF, 16'h0000);
    issue(9, 0, 1, 1, 16'h0006, 16'h0000);
    issue(0, 3, 1, 1, 16'h1234, 16'h4321, 5);
    issue(6, 1, 0, 0, 16'h00A5, 16'h00A5, 3);

    // Abort a len=3 op with reset mid-RUN: no done_o may follow
    t = 0;
    while (!ready_o && t < 64) begin step(); t++; end
    chk("abort_ready", ready_o, 1);
    op_i = 4'd0; len_i = 2'd3; a_i = 16'h1111; b_i = 16'h2222; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    chk("abort_busy", busy_o, 1);
    rst = 1'b1;
    step();
    chk("abort_ready_rst", ready_o, 1);
    chk("abort_busy_rst", busy_o, 0);
    chk("abort_done_rst", done_o, 0);
    chk("abort_result_rst", result_o, 0);
    chk("abort_carry_rst", carry_o, 0);
    chk("abort_zero_rst", zero_o, 0);
    rst = 1'b0;
    repeat (8) step();

    for (int i = 0; i < 250; i++) begin
      ln = int'($urandom_range(0, 3));
      issue(int'($urandom_range(0, 15)), ln, 1'($urandom), 1'($urandom),
            W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0) ? ln + 2 : 0);
      repeat ($urandom_range(0, 2)) step();
    end

    t = 0;
    while (sb.size() != 0 && t < 100) begin step(); t++; end
    chk("drain", sb.size(), 0);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
